// File: rtl/b64_job_sched_pkg.sv
// Shared types and helpers for the Base64 job scheduler.
// Holds the FSM state encoding, the output-length helper and the default watchdog limit.
package b64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int DEF_TIMEOUT = 4000;

  // Base64 emits four characters per started group of three input bytes.
  function automatic logic [31:0] chars_for_len(input logic [31:0] len);
    return ((len + 32'd2) / 32'd3) * 32'd4;
  endfunction

endpackage

// File: rtl/b64_job_sched_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after the pointer, wrapping past N-1.
module rr_pick
  import b64_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int cand;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    cand     = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(i_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!o_any && i_req[IDX_W'(cand)]) begin
        o_any                  = 1'b1;
        o_onehot[IDX_W'(cand)] = 1'b1;
        o_idx                  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/b64_job_sched.sv
// Round-robin scheduler sharing one base64_enc core between N_REQ requesters,
// with a RUN-state watchdog and per-requester done/error pulses.
module b64_job_sched
  import b64_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*LEN_W-1:0]   req_len,
  output logic [N_REQ-1:0]         req_grant,
  output logic [N_REQ-1:0]         req_done,
  output logic [N_REQ-1:0]         req_err,
  output logic                     enc_start,
  output logic [$clog2(N_REQ)-1:0] enc_sel,
  output logic [LEN_W-1:0]         enc_len,
  output logic [LEN_W+1:0]         enc_chars,
  input  logic                     enc_complete,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [WD_W-1:0]    r_wd;
  logic               r_cmpPrev;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_done;
  logic [N_REQ-1:0]   r_err;
  logic               r_start;
  logic [IDX_W-1:0]   r_sel;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W+1:0]   r_chars;

  logic [N_REQ-1:0]   w_onehot;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W+1:0]   w_chars;
  logic [IDX_W-1:0]   w_nextPtr;
  logic               w_edge;
  logic               w_expired;

  rr_pick #(
    .N    (N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_onehot(w_onehot),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_len     = req_len[w_idx*LEN_W +: LEN_W];
  assign w_chars   = (LEN_W+2)'(chars_for_len(32'(w_len)));
  assign w_nextPtr = (r_sel == IDX_W'(N_REQ-1)) ? '0 : r_sel + 1'b1;
  assign w_edge    = enc_complete & ~r_cmpPrev;
  assign w_expired = (r_wd == WD_W'(TIMEOUT-1));

  // A level already high when RUN begins must not count as completion.
  always_ff @(posedge clk) begin
    if (reset) r_cmpPrev <= 1'b0;
    else       r_cmpPrev <= enc_complete;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_wd    <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_start <= 1'b0;
      r_sel   <= '0;
      r_len   <= '0;
      r_chars <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_onehot;
            r_sel   <= w_idx;
            r_len   <= w_len;
            r_chars <= w_chars;
            r_start <= (w_len != '0);
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_wd <= '0;
          if (r_len == '0) begin
            r_done  <= r_grant;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        // Completion takes priority over a watchdog expiry in the same cycle.
        ST_RUN: begin
          if (w_edge) begin
            r_done  <= r_grant;
            r_state <= ST_DONE;
          end else if (w_expired) begin
            r_err   <= r_grant;
            r_state <= ST_ERR;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          r_grant <= '0;
          r_ptr   <= w_nextPtr;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_grant = r_grant;
  assign req_done  = r_done;
  assign req_err   = r_err;
  assign enc_start = r_start;
  assign enc_sel   = r_sel;
  assign enc_len   = r_len;
  assign enc_chars = r_chars;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_b64_job_sched.sv
// Directed, table-driven bench for b64_job_sched (N_REQ=4, LEN_W=16, TIMEOUT=50).
module tb_b64_job_sched;

  localparam int N_REQ   = 4;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_len;
  logic [3:0]  req_grant;
  logic [3:0]  req_done;
  logic [3:0]  req_err;
  logic        enc_start;
  logic [1:0]  enc_sel;
  logic [15:0] enc_len;
  logic [17:0] enc_chars;
  logic        enc_complete;
  logic        busy;

  int nCompared = 0;
  int nMismatch = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] lens;
    int          expIdx;
    logic [15:0] expLen;
    logic [17:0] expChars;
  } vec_t;

  vec_t vecs[11];

  b64_job_sched #(
    .N_REQ  (N_REQ),
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_len     (req_len),
    .req_grant   (req_grant),
    .req_done    (req_done),
    .req_err     (req_err),
    .enc_start   (enc_start),
    .enc_sel     (enc_sel),
    .enc_len     (enc_len),
    .enc_chars   (enc_chars),
    .enc_complete(enc_complete),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [63:0] lens, input logic complete);
    req_valid    = valid;
    req_len      = lens;
    enc_complete = complete;
  endtask

  // One full job with a prompt completion edge; leaves the DUT back in IDLE.
  task automatic serveJob(input string tag, input int expIdx, input logic [15:0] expLen, input logic [17:0] expChars);
    logic [3:0] expOneHot;
    expOneHot = 4'(32'd1 << expIdx);
    tick();
    checkOutput({tag, ".grant"}, 32'(req_grant), 32'(expOneHot));
    checkOutput({tag, ".sel"},   32'(enc_sel),   32'(expIdx));
    checkOutput({tag, ".len"},   32'(enc_len),   32'(expLen));
    checkOutput({tag, ".chars"}, 32'(enc_chars), 32'(expChars));
    checkOutput({tag, ".start"}, 32'(enc_start), 32'd1);
    checkOutput({tag, ".busy"},  32'(busy),      32'd1);
    req_len = ~req_len;
    tick();
    checkOutput({tag, ".startLow"}, 32'(enc_start), 32'd0);
    enc_complete = 1'b1;
    tick();
    checkOutput({tag, ".done"},       32'(req_done),  32'(expOneHot));
    checkOutput({tag, ".noErr"},      32'(req_err),   32'd0);
    checkOutput({tag, ".grantHeld"},  32'(req_grant), 32'(expOneHot));
    checkOutput({tag, ".lenHeld"},    32'(enc_len),   32'(expLen));
    checkOutput({tag, ".charsHeld"},  32'(enc_chars), 32'(expChars));
    enc_complete = 1'b0;
    req_valid    = 4'b0000;
    tick();
    checkOutput({tag, ".grantDrop"}, 32'(req_grant), 32'd0);
    checkOutput({tag, ".idle"},      32'(busy),      32'd0);
    checkOutput({tag, ".doneOnce"},  32'(req_done),  32'd0);
  endtask

  initial begin
    int stray;

    vecs[0]  = '{4'b0100, {16'd0, 16'd5, 16'd0, 16'd0},     2, 16'd5,     18'd8};
    vecs[1]  = '{4'b1111, {16'd7, 16'd3, 16'd2, 16'd1},     3, 16'd7,     18'd12};
    vecs[2]  = '{4'b1111, {16'd7, 16'd3, 16'd2, 16'd1},     0, 16'd1,     18'd4};
    vecs[3]  = '{4'b1111, {16'd7, 16'd3, 16'd2, 16'd1},     1, 16'd2,     18'd4};
    vecs[4]  = '{4'b1111, {16'd7, 16'd3, 16'd2, 16'd1},     2, 16'd3,     18'd4};
    vecs[5]  = '{4'b1111, {16'd7, 16'd3, 16'd2, 16'd1},     3, 16'd7,     18'd12};
    vecs[6]  = '{4'b1111, {16'd7, 16'd3, 16'd2, 16'd65535}, 0, 16'd65535, 18'd87380};
    vecs[7]  = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd6},     0, 16'd6,     18'd8};
    vecs[8]  = '{4'b1001, {16'd4, 16'd0, 16'd0, 16'd9},     3, 16'd4,     18'd8};
    vecs[9]  = '{4'b0110, {16'd0, 16'd300, 16'd8, 16'd0},   1, 16'd8,     18'd12};
    vecs[10] = '{4'b0011, {16'd0, 16'd0, 16'd11, 16'd10},   0, 16'd10,    18'd16};

    reset = 1'b1;
    applyStimulus(4'b0000, 64'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst.grant", 32'(req_grant), 32'd0);
    checkOutput("rst.busy",  32'(busy),      32'd0);
    checkOutput("rst.start", 32'(enc_start), 32'd0);
    checkOutput("rst.chars", 32'(enc_chars), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].lens, 1'b0);
      serveJob($sformatf("vec%0d", i), vecs[i].expIdx, vecs[i].expLen, vecs[i].expChars);
    end

    // Zero-length job: pointer is at 1, done two cycles after the request.
    applyStimulus(4'b0010, 64'd0, 1'b0);
    tick();
    checkOutput("zero.grant", 32'(req_grant), 32'b0010);
    checkOutput("zero.start", 32'(enc_start), 32'd0);
    tick();
    checkOutput("zero.done",  32'(req_done),  32'b0010);
    checkOutput("zero.start2", 32'(enc_start), 32'd0);
    req_valid = 4'b0000;
    tick();
    checkOutput("zero.idle", 32'(busy), 32'd0);

    // Watchdog expiry with enc_complete held low.
    applyStimulus(4'b0100, {16'd0, 16'd5, 16'd0, 16'd0}, 1'b0);
    tick();
    checkOutput("to.start", 32'(enc_start), 32'd1);
    stray = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (req_done != 4'b0000 || req_err != 4'b0000) stray++;
    end
    checkOutput("to.quiet", 32'(stray), 32'd0);
    tick();
    checkOutput("to.err",   32'(req_err),  32'b0100);
    checkOutput("to.noDone", 32'(req_done), 32'd0);
    req_valid = 4'b0000;
    tick();
    checkOutput("to.grantDrop", 32'(req_grant), 32'd0);
    applyStimulus(4'b1100, {16'd6, 16'd5, 16'd0, 16'd0}, 1'b0);
    serveJob("afterTo", 3, 16'd6, 18'd8);

    // enc_complete high from before the grant never forms an edge.
    applyStimulus(4'b0001, {16'd0, 16'd0, 16'd0, 16'd2}, 1'b1);
    tick();
    stray = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (req_done != 4'b0000 || req_err != 4'b0000) stray++;
    end
    checkOutput("held.quiet", 32'(stray), 32'd0);
    tick();
    checkOutput("held.err",    32'(req_err),  32'b0001);
    checkOutput("held.noDone", 32'(req_done), 32'd0);
    applyStimulus(4'b0000, 64'd0, 1'b0);
    tick();

    // Completion edge landing on the expiry cycle wins.
    applyStimulus(4'b0010, {16'd0, 16'd0, 16'd4, 16'd0}, 1'b0);
    tick();
    for (int k = 1; k <= TIMEOUT; k++) tick();
    checkOutput("race.stillRun", 32'(req_grant), 32'b0010);
    enc_complete = 1'b1;
    tick();
    checkOutput("race.done",  32'(req_done), 32'b0010);
    checkOutput("race.noErr", 32'(req_err),  32'd0);
    applyStimulus(4'b0000, 64'd0, 1'b0);
    tick();

    // Reset in the middle of RUN aborts silently and clears the pointer.
    applyStimulus(4'b0100, {16'd0, 16'd5, 16'd0, 16'd0}, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("mid.running", 32'(req_grant), 32'b0100);
    reset = 1'b1;
    tick();
    checkOutput("mid.grant", 32'(req_grant), 32'd0);
    checkOutput("mid.busy",  32'(busy),      32'd0);
    checkOutput("mid.done",  32'(req_done),  32'd0);
    checkOutput("mid.err",   32'(req_err),   32'd0);
    checkOutput("mid.sel",   32'(enc_sel),   32'd0);
    checkOutput("mid.len",   32'(enc_len),   32'd0);
    tick();
    checkOutput("mid.quiet", 32'({req_done, req_err}), 32'd0);
    reset = 1'b0;
    applyStimulus(4'b0110, {16'd0, 16'd5, 16'd3, 16'd0}, 1'b0);
    serveJob("postRst", 1, 16'd3, 18'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/b64_job_sched.md
# b64_job_sched

Round-robin job scheduler that shares one `base64_enc` core among `N_REQ` requesters. Accepts one message job per requester, hands the core a start pulse with length and source select, and supervises completion with a watchdog. Reports per-requester done/error and the expected Base64 output character count. Sits between the requester front-ends and the single encoder instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `LEN_W`, 16: width of message byte length.
- `TIMEOUT`, 4000: cycles allowed in RUN before abort, ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i has a pending job; held until its `req_done` or `req_err`.
- `req_len`  in  N_REQ*LEN_W  flattened byte lengths, slice i = `[i*LEN_W +: LEN_W]`.
- `req_grant`  out  N_REQ  one-hot owner of the core, or zero.
- `req_done`  out  N_REQ  one-cycle pulse, job i completed.
- `req_err`  out  N_REQ  one-cycle pulse, job i timed out.
- `enc_start`  out  1  one-cycle start pulse to core.
- `enc_sel`  out  $clog2(N_REQ)  index of granted requester, valid while granted.
- `enc_len`  out  LEN_W  byte length of granted job.
- `enc_chars`  out  LEN_W+2  output characters = 4*ceil(len/3).
- `enc_complete`  in  1  core completion; rising edge is significant.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM: IDLE, START, RUN, DONE, ERR.
- IDLE: if any `req_valid` set, pick the first set bit at or after `rr_ptr` (wrapping), register grant/sel/len/chars, go to START. Otherwise stay.
- START: `enc_start`=1 for exactly one cycle; clear watchdog; go to RUN. If `enc_len`==0, skip the core: no `enc_start`, go straight to DONE.
- RUN: wait for a rising edge of `enc_complete` (registered previous value, 0→1) → DONE. The watchdog counts each RUN cycle; when it reaches `TIMEOUT`-1 without an edge → ERR. An edge and the expiry in the same cycle → DONE (completion wins).
- DONE: pulse `req_done[sel]`, drop grant, `rr_ptr`=sel+1 mod N_REQ, → IDLE.
- ERR: pulse `req_err[sel]`, drop grant, advance `rr_ptr` the same way, → IDLE.
- Changes to `req_valid` or `req_len` after the grant are ignored until IDLE.
- `enc_chars` = ((len+2)/3)*4, integer divide, computed at grant. No overflow at LEN_W+2 bits.
- Reset values: state IDLE, `rr_ptr`=0, watchdog 0, all outputs 0. Reset mid-RUN aborts silently with no done/err pulse; the core is reset by the same `reset`.

## Timing
- `req_valid` seen in IDLE at cycle t: grant at t+1, `enc_start` high during t+1 (START), RUN from t+2.
- `enc_complete` edge sampled at cycle c: `req_done` and grant drop at c+1, IDLE at c+2, next grant earliest c+2.
- Zero-length job: grant t+1, `req_done` t+2, no `enc_start`.
- Timeout: `req_err` exactly `TIMEOUT`+1 cycles after START.
- `req_grant`, `enc_sel`, `enc_len`, `enc_chars` stay stable from START through DONE/ERR inclusive.

## Structure
- Package `b64_pkg`: FSM state enum, `chars_for_len()` function, default `TIMEOUT` constant.
- One sub-module: `rr_pick`, a combinational round-robin priority picker (request vector plus pointer in; one-hot and index out).
- Watchdog and edge detect stay inline.

## Test plan
- N_REQ=4, only req 2 valid, len=5 → grant 0100, `enc_start` pulse, `enc_chars`=8. Complete edge → `req_done[2]` pulse, next `rr_ptr`=3.
- All four valid, fast completions → grant order 0,1,2,3,0. Each grant lasts until its done.
- req 1 len=0 → `req_done[1]` 2 cycles after request; `enc_start` never asserts.
- TIMEOUT=50, `enc_complete` held low → `req_err` at START+51, no `req_done`. Next requester is served.
- Complete edge on the exact expiry cycle → `req_done`, not `req_err`. `enc_complete` held high from before START does not count as completion.
- `reset` pulsed mid-RUN → all outputs 0 next cycle, no pulses. A fresh request is then granted to the lowest valid index at or after 0.
